// File: rtl/rr_control_sequencer.sv
// rr_control_sequencer: FSM issuing datapath control strobes for fetch + register-register ALU execution
module rr_control_sequencer #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 16,
  parameter int SEL_W    = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              run,
  input  logic [DATA_W-1:0] ir,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              ZLowIn,
  output logic              ZHighIn,
  output logic              ZLowOut,
  output logic              ZHighOut,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout,
  output logic [4:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
  state_t state, next;
  logic [3:0] wcnt;
  logic [4:0] op;
  logic [SEL_W-1:0] ra, rb, rc, ra_n;
  logic muldiv, alu, legal, wait_done, unused_ir;
  assign op        = ir[DATA_W-1 -: 5];
  assign ra        = ir[DATA_W-6 -: SEL_W];
  assign rb        = ir[DATA_W-6-SEL_W -: SEL_W];
  assign rc        = ir[DATA_W-6-2*SEL_W -: SEL_W];
  assign unused_ir = ^ir;
  assign muldiv    = op == 5'h0F || op == 5'h10;
  assign alu       = op inside {5'h03, 5'h04, 5'h05, 5'h06};
  assign legal     = (alu || muldiv) && {1'b0, ra} < (SEL_W+1)'(NREG)
                     && {1'b0, rb} < (SEL_W+1)'(NREG) && {1'b0, rc} < (SEL_W+1)'(NREG);
  // second half of a 64-bit result goes to the next register, wrapping at NREG
  assign ra_n      = (ra == SEL_W'(NREG-1)) ? '0 : ra + 1'b1;
  assign wait_done = wcnt == 4'(MEM_WAIT);
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      wcnt    <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= next;
      wcnt    <= (state == T1 && !wait_done) ? wcnt + 4'd1 : 4'd0;
      done    <= (state == T5 && !muldiv) || state == T6;
      illegal <= state == T3 && !legal;
    end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? T0 : IDLE;
      T0:      next = T1;
      T1:      next = wait_done ? T2 : T1;
      T2:      next = T3;
      T3:      next = legal ? T4 : IDLE;
      T4:      next = T5;
      T5:      next = muldiv ? T6 : (run ? T0 : IDLE);
      T6:      next = run ? T0 : IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin} = '0;
    {ZLowIn, ZHighIn, ZLowOut, ZHighOut} = '0;
    Rin    = '0;
    Rout   = '0;
    busy   = state != IDLE;
    alu_op = (state inside {T3, T4, T5, T6}) ? op : 5'd0;
    case (state)
      T0: {PCout, MARin, IncPC, ZLowIn} = '1;
      T1: {ZLowOut, Read, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3: begin
        Yin  = legal;
        Rout = legal ? NREG'(1) << rb : '0;
      end
      T4: begin
        ZLowIn  = 1'b1;
        ZHighIn = muldiv;
        Rout    = NREG'(1) << rc;
      end
      T5: begin
        ZLowOut = 1'b1;
        Rin     = NREG'(1) << ra;
      end
      T6: begin
        ZHighOut = 1'b1;
        Rin      = NREG'(1) << ra_n;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_rr_control_sequencer.sv
// tb_rr_control_sequencer: cycle-trace scoreboard against a phase-table model of the sequencer
module tb_rr_control_sequencer;
  localparam int NR = 12;
  localparam int MW = 1;
  localparam logic [11:0] S_PC = 12'h800, S_MAR = 12'h400, S_INC = 12'h200, S_RD = 12'h100;
  localparam logic [11:0] S_MDRI = 12'h080, S_MDRO = 12'h040, S_IRI = 12'h020, S_Y = 12'h010;
  localparam logic [11:0] S_ZLI = 12'h008, S_ZHI = 12'h004, S_ZLO = 12'h002, S_ZHO = 12'h001;
  typedef struct packed {
    logic [11:0]   s;
    logic [NR-1:0] rin;
    logic [NR-1:0] rout;
    logic [4:0]    op;
    logic          busy;
    logic          done;
    logic          ill;
  } rec_t;
  logic clock, clear, start, run;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn, ZLowOut, ZHighOut;
  logic [NR-1:0] Rin, Rout;
  logic [4:0] alu_op;
  logic busy, done, illegal;
  rec_t act, exp_r;
  rec_t q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [4:0] ops [6] = '{5'h03, 5'h04, 5'h05, 5'h06, 5'h0F, 5'h10};

  rr_control_sequencer #(.DATA_W(32), .NREG(NR), .SEL_W(4), .MEM_WAIT(MW)) dut (
    .clock(clock), .clear(clear), .start(start), .run(run), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done),
    .illegal(illegal));

  assign act = {PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin, ZLowIn, ZHighIn, ZLowOut,
                ZHighOut, Rin, Rout, alu_op, busy, done, illegal};

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // monitor: every cycle the DUT outputs must equal the next queued expectation (all-zero when idle)
  always @(posedge clock) begin
    #1;
    cyc++;
    exp_r = '0;
    if (q.size() != 0) exp_r = q.pop_front();
    vectors++;
    if (act !== exp_r) begin
      miscompares++;
      $display("FAIL trace cyc %0d: got s=%h rin=%h rout=%h op=%h bdi=%b%b%b, exp s=%h rin=%h rout=%h op=%h bdi=%b%b%b",
               cyc, act.s, act.rin, act.rout, act.op, act.busy, act.done, act.ill,
               exp_r.s, exp_r.rin, exp_r.rout, exp_r.op, exp_r.busy, exp_r.done, exp_r.ill);
    end
  end

  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    logic [31:0] v;
    v = {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    return v;
  endfunction

  // model: one record per cycle from T0 until the last busy phase of the instruction
  task automatic push_instr(input logic [31:0] i, input bit d0, output bit ok);
    int op, ra, rb, rc;
    bit md;
    rec_t r;
    op = int'(i[31:27]); ra = int'(i[26:23]); rb = int'(i[22:19]); rc = int'(i[18:15]);
    md = op == 15 || op == 16;
    ok = (op inside {3, 4, 5, 6, 15, 16}) && ra < NR && rb < NR && rc < NR;
    r = '0; r.busy = 1; r.done = d0;
    r.s = S_PC | S_MAR | S_INC | S_ZLI; q.push_back(r);
    r.done = 0;
    r.s = S_ZLO | S_RD | S_MDRI;
    repeat (1 + MW) q.push_back(r);
    r.s = S_MDRO | S_IRI; q.push_back(r);
    r.op = 5'(op);
    r.s = ok ? S_Y : 12'h0;
    r.rout = ok ? NR'(1) << rb : '0;
    q.push_back(r);
    if (!ok) return;
    r.s = S_ZLI | (md ? S_ZHI : 12'h0); r.rout = NR'(1) << rc; q.push_back(r);
    r.s = S_ZLO; r.rout = '0; r.rin = NR'(1) << ra; q.push_back(r);
    if (md) begin
      r.s = S_ZHO; r.rin = NR'(1) << ((ra + 1) % NR); q.push_back(r);
    end
  endtask

  task automatic push_tail(input bit ok);
    rec_t t;
    t = '0;
    t.done = ok;
    t.ill = !ok;
    q.push_back(t);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clock);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain timeout: %0d records left, required 0", q.size());
      q.delete();
    end
    @(negedge clock);
  endtask

  task automatic run_one(input logic [31:0] i, input bit poke);
    bit ok;
    @(negedge clock);
    ir = i; start = 1;
    push_instr(i, 0, ok);
    push_tail(ok);
    @(negedge clock);
    start = 0;
    if (poke) begin
      repeat (2) @(negedge clock);
      start = 1;
      @(negedge clock);
      start = 0;
    end
    wait_drain();
  endtask

  task automatic run_pair(input logic [31:0] i1, input logic [31:0] i2);
    bit ok;
    int n1;
    @(negedge clock);
    ir = i1; start = 1; run = 1;
    push_instr(i1, 0, ok);
    n1 = q.size();
    push_instr(i2, 1, ok);
    push_tail(ok);
    @(negedge clock);
    start = 0;
    repeat (n1) @(negedge clock);
    ir = i2; run = 0;
    wait_drain();
  endtask

  task automatic clear_test();
    bit ok;
    @(negedge clock);
    ir = mk(3, 1, 2, 3); start = 1;
    push_instr(ir, 0, ok);
    push_tail(ok);
    @(negedge clock);
    start = 0;
    repeat (4) @(negedge clock);
    @(posedge clock);
    #3 clear = 1;
    q.delete();
    #1;
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL async_clear: outputs %h, required 0", act);
    end
    @(negedge clock);
    @(negedge clock);
    clear = 0;
  endtask

  function automatic logic [31:0] rand_ir(input bit legal_only);
    int op;
    op = (!legal_only && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                    : int'(ops[$urandom_range(0, 5)]);
    return legal_only ? mk(op, $urandom_range(0, NR-1), $urandom_range(0, NR-1), $urandom_range(0, NR-1))
                      : mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
  endfunction

  initial begin
    clear = 1; start = 0; run = 0; ir = '0;
    repeat (3) @(negedge clock);
    clear = 0;
    run_one(mk(5'h03, 4, 3, 7), 0);
    run_one(mk(5'h0F, NR-1, 2, 5), 0);
    run_one(mk(5'h10, 0, 11, 1), 1);
    run_one(mk(5'h1F, 1, 2, 3), 0);
    run_one(mk(5'h03, 1, 2, 13), 0);
    run_one(mk(5'h04, 15, 0, 0), 1);
    run_pair(mk(5'h04, 2, 3, 4), mk(5'h04, 5, 6, 7));
    run_pair(mk(5'h0F, 9, 1, 2), mk(5'h05, 0, 0, 0));
    clear_test();
    run_one(mk(5'h06, 8, 9, 10), 0);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) run_pair(rand_ir(1), rand_ir(1));
      else run_one(rand_ir(0), $urandom_range(0, 1) == 1);
    end
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_control_sequencer.md
Name: rr_control_sequencer

Overview:
Parametrised micro-sequencer that drives the datapath control strobes for fetch plus register-register ALU execution. It replaces hand-sequenced T0..T5 strobing with a synthesizable FSM, and adds configurable register count, memory wait states, MUL/DIV 64-bit write-back, illegal-opcode trap and free-run mode. It sits beside the datapath and connects one-to-one to its PC/MAR/MDR/IR/Y/Z/register-file strobes.

Parameters:
DATA_W, 32, datapath/IR width (min 17)
NREG, 16, number of general registers (2..2**SEL_W)
SEL_W, 4, register-select field width in IR
MEM_WAIT, 1, extra cycles Read/MDRin held in T1 (0..15)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
start  in  1  begin one instruction when IDLE
run  in  1  1 = auto-restart at T0 after each instruction
ir  in  DATA_W  IR contents from datapath
PCout  out  1  drive PC onto bus
MARin  out  1  load MAR
IncPC  out  1  ALU computes PC+1
Read  out  1  memory read to MDR
MDRin  out  1  load MDR
MDRout  out  1  drive MDR onto bus
IRin  out  1  load IR
Yin  out  1  load Y
ZLowIn  out  1  load Z low
ZHighIn  out  1  load Z high
ZLowOut  out  1  drive Z low onto bus
ZHighOut  out  1  drive Z high onto bus
Rin  out  NREG  one-hot register write enable
Rout  out  NREG  one-hot register bus drive
alu_op  out  5  ALU operation select (= ir opcode during T3..T6, else 0)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: instruction retired
illegal  out  1  one-cycle pulse: opcode/register trap

Behaviour:
- IR fields: op=ir[DATA_W-1 -: 5], Ra=ir[DATA_W-6 -: SEL_W], Rb=next SEL_W bits, Rc=next SEL_W bits.
- Opcodes: ADD 5'h03, SUB 5'h04, AND 5'h05, OR 5'h06, MUL 5'h0F, DIV 5'h10; all others illegal.
- Any of Ra/Rb/Rc >= NREG is illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Strobes are Moore outputs decoded from the state register. At most one bus driver is active per state.
- IDLE: all strobes 0. Moves to T0 when start=1.
- T0: PCout, MARin, IncPC, ZLowIn.
- T1: ZLowOut, PCin-equivalent is not driven (PC self-loads on IncPC), Read, MDRin. Held for 1+MEM_WAIT cycles using a wait counter, then goes to T2.
- T2: MDRout, IRin.
- T3: decode the ir inputs (IR is valid from this cycle).
  - Illegal: no strobes, illegal=1 for one cycle, then IDLE. No Rin is ever asserted.
  - Legal: Rout[Rb], Yin.
- T4: Rout[Rc], ZLowIn. MUL/DIV also assert ZHighIn.
- T5: ZLowOut, Rin[Ra].
  - ADD/SUB/AND/OR: done pulses on the transition out of T5.
  - MUL/DIV: go to T6.
- T6 (MUL/DIV only): ZHighOut, Rin[(Ra+1) mod NREG]. done pulses on exit.
- After retirement: if run=1, go to T0, else IDLE. done is registered and asserted in the first cycle of the next state.
- start while busy: ignored. start and clear together: clear wins.
- clear asserted in any state: state=IDLE, wait counter=0, and every output (strobes, Rin, Rout, alu_op, busy, done, illegal) goes to 0 immediately, without waiting for a clock edge. No partial register write may follow.
- Latency from start to done:
  - ALU ops: 6+MEM_WAIT cycles.
  - MUL/DIV: 7+MEM_WAIT cycles.
  - Illegal: illegal pulses 4+MEM_WAIT cycles after start.

Test Plan:
- NREG=16, MEM_WAIT=1, run=0; ir=ADD Ra=4 Rb=3 Rc=7; pulse start -> T1 Read/MDRin high exactly 2 cycles; T3 Rout=16'h0008 with Yin; T4 Rout=16'h0080 with ZLowIn; T5 Rin=16'h0010 with ZLowOut; done 7 cycles after start.
- MUL Ra=15 Rb=2 Rc=5 -> T4 ZHighIn and ZLowIn both high; T5 Rin[15]; T6 ZHighOut with Rin[0] (wrap); done 8 cycles after start.
- ir opcode 5'h1F -> illegal pulse in the cycle after T3, Rin==0 in every cycle, busy low afterwards.
- NREG=8 and an ADD with Rc=9 -> illegal pulse, no Rin asserted.
- run=1 across two SUB instructions, MEM_WAIT=0 -> T0 follows T5 directly, two done pulses 6 cycles apart, busy held high throughout.
- clear asserted mid-T4 (asynchronously, between clock edges) -> all outputs 0 before the next clock edge, state IDLE; after clear is released, start runs a full instruction correctly.
